// File: rtl/uart_tx_stream.sv
// UART transmitter fed by a small input FIFO: LSB-first frames with optional
// parity and one or two stop bits, latched per frame, at CLKS_PER_BIT clocks per bit.
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit (low)
// DATA   | DATA_W data bits, LSB first
// PARITY | parity bit (only when latched parity_en=1)
// STOP   | one or two stop bits (high); pops the next word on the last cycle
module uart_tx_stream #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              parity_en,
  input  logic                              parity_odd,
  input  logic                              two_stop,
  output logic                              tx,
  output logic                              busy,
  output logic                              frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_q;
  logic              push, pop, load;

  state_t            state_q, state_n;
  logic [TW-1:0]     timer_q;
  logic [IW-1:0]     bit_idx_q;
  logic              stop_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_en_q, par_bit_q, two_stop_q;
  logic              bit_end, tx_n, done_n;
  logic [DATA_W-1:0] head;

  assign in_ready   = (count_q != CW'(FIFO_DEPTH));
  assign fifo_count = count_q;
  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr];
  assign bit_end    = (timer_q == TW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= in_data;
  end

  // tx/busy/frame_done are registered from the current state, so the line
  // trails the state register by one cycle but never glitches.
  always_comb begin
    state_n = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    tx_n    = 1'b1;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx_n = shift_q[0];
        if (bit_end && bit_idx_q == IW'(DATA_W - 1))
          state_n = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_n = par_bit_q;
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end && stop_idx_q == two_stop_q) begin
          done_n = 1'b1;
          if (count_q != '0) begin
            pop     = 1'b1;
            load    = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      tx         <= tx_n;
      busy       <= (state_q != IDLE);
      frame_done <= done_n;

      if (state_q == IDLE || load || bit_end) timer_q <= '0;
      else                                    timer_q <= timer_q + 1'b1;

      if (load) begin
        shift_q    <= head;
        par_en_q   <= parity_en;
        par_bit_q  <= (^head) ^ parity_odd;
        two_stop_q <= two_stop;
      end else if (state_q == DATA && bit_end) begin
        shift_q <= shift_q >> 1;
      end

      if (state_q != DATA)  bit_idx_q <= '0;
      else if (bit_end)     bit_idx_q <= bit_idx_q + 1'b1;

      if (state_q != STOP)  stop_idx_q <= 1'b0;
      else if (bit_end)     stop_idx_q <= 1'b1;
    end
  end

endmodule
